// File: rtl/agex_muldiv_if.sv
// Handshake bundle between AGEX, the mul/div unit and the MEM-bound result path.
interface agex_muldiv_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/agex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the AGEX stage.
// Magnitudes are processed unsigned (shift-add / restoring shift-subtract)
// and the sign is applied on the final step.
// Optional: define AGEX_MULDIV_FASTMUL_EN for a single-cycle multiplier.
module agex_muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input logic          clk,
  input logic          reset,
  agex_muldiv_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned PW    = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e           state, state_nx;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [XLEN-1:0]  hi_q, lo_q, dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  result_q;
  logic [TAG_W-1:0] tag_q;

  logic             accept, is_div, a_sgn, b_sgn, sa, sb, res_neg;
  logic             div_zero, div_ovf, direct;
  logic [XLEN-1:0]  mag_a, mag_b, direct_res;
`ifdef AGEX_MULDIV_FASTMUL_EN
  logic [PW-1:0]    prod_fast;
`endif

  logic [XLEN:0]    add_sum, sub_pre, sub_diff;
  logic [XLEN-1:0]  hi_nx, lo_nx, div_raw, div_fix, fin_res;
  logic [PW-1:0]    prod_fix;

  assign bus.in_ready   = (state == S_IDLE) && !bus.flush;
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.busy       = (state != S_IDLE);
  assign bus.out_valid  = (state == S_DONE);
  assign bus.out_result = result_q;
  assign bus.out_tag    = tag_q;

  // Operand decode: signedness, magnitudes, special cases resolved at accept
  always_comb begin
    is_div   = bus.in_op[2];
    a_sgn    = is_div ? ~bus.in_op[0] : (bus.in_op[1:0] != 2'b11);
    b_sgn    = is_div ? ~bus.in_op[0] : ~bus.in_op[1];
    sa       = a_sgn & bus.in_a[XLEN-1];
    sb       = b_sgn & bus.in_b[XLEN-1];
    mag_a    = sa ? (~bus.in_a + XLEN'(1)) : bus.in_a;
    mag_b    = sb ? (~bus.in_b + XLEN'(1)) : bus.in_b;
    res_neg  = (is_div && bus.in_op[1]) ? sa : (sa ^ sb);
    div_zero = is_div && (bus.in_b == '0);
    div_ovf  = is_div && ~bus.in_op[0] && (bus.in_b == '1) &&
               (bus.in_a == {1'b1, {(XLEN-1){1'b0}}});
    direct   = div_zero || div_ovf;
    if (div_zero) direct_res = bus.in_op[1] ? bus.in_a : '1;
    else          direct_res = bus.in_op[1] ? '0 : bus.in_a;
`ifdef AGEX_MULDIV_FASTMUL_EN
    prod_fast = {{XLEN{sa}}, bus.in_a} * {{XLEN{sb}}, bus.in_b};
    if (!is_div) begin
      direct     = 1'b1;
      direct_res = (bus.in_op[1:0] == 2'b00) ? prod_fast[XLEN-1:0] : prod_fast[PW-1:XLEN];
    end
`endif
  end

  // One iteration step plus the sign fix-up applied on the final step
  always_comb begin
    add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dsr_q} : '0);
    sub_pre  = {hi_q, lo_q[XLEN-1]};
    sub_diff = sub_pre - {1'b0, dsr_q};
    if (op_q[2]) begin
      hi_nx = sub_diff[XLEN] ? sub_pre[XLEN-1:0] : sub_diff[XLEN-1:0];
      lo_nx = {lo_q[XLEN-2:0], ~sub_diff[XLEN]};
    end else begin
      hi_nx = add_sum[XLEN:1];
      lo_nx = {add_sum[0], lo_q[XLEN-1:1]};
    end
    prod_fix = neg_q ? (~{hi_nx, lo_nx} + PW'(1)) : {hi_nx, lo_nx};
    div_raw  = op_q[1] ? hi_nx : lo_nx;
    div_fix  = neg_q ? (~div_raw + XLEN'(1)) : div_raw;
    if (op_q[2])                 fin_res = div_fix;
    else if (op_q[1:0] == 2'b00) fin_res = prod_fix[XLEN-1:0];
    else                         fin_res = prod_fix[PW-1:XLEN];
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM next state; flush wins over every other transition
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = direct ? S_DONE : S_BUSY;
      S_BUSY:  if (cnt_q == CNT_W'(1)) state_nx = S_DONE;
      S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (bus.flush) state_nx = S_IDLE;
  end

  // Datapath: load on accept, iterate while busy, capture result on last step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else if (accept) begin
      op_q  <= bus.in_op;
      neg_q <= res_neg;
      hi_q  <= '0;
      lo_q  <= is_div ? mag_a : mag_b;
      dsr_q <= is_div ? mag_b : mag_a;
      cnt_q <= CNT_W'(XLEN);
      tag_q <= bus.in_tag;
      if (direct) result_q <= direct_res;
    end else if ((state == S_BUSY) && !bus.flush) begin
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) result_q <= fin_res;
    end
  end
endmodule

// File: tb/tb_agex_muldiv_unit.sv
// Directed bench for agex_muldiv_unit: vector table plus handshake/flush/reset sequences.
module tb_agex_muldiv_unit;
  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
`ifdef AGEX_MULDIV_FASTMUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif
  localparam int DL = 33;
  localparam int NV = 18;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] res;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  vec_t vecs [NV];

  agex_muldiv_if #(.XLEN(32), .TAG_W(5)) bus ();

  agex_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    @(negedge clk);
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Cycles counted with the accept cycle as 0; bounded wait
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int lat;
    total = 0;
    passed = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = '0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;

    vecs[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, ML};
    vecs[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 5'd1,  32'h40000000, ML};
    vecs[2]  = '{OP_MULHU,  32'h80000000, 32'h80000000, 5'd2,  32'h40000000, ML};
    vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, ML};
    vecs[4]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, ML};
    vecs[5]  = '{OP_MUL,    32'hFFFFFFFD, 32'hFFFFFFFB, 5'd6,  32'd15,       ML};
    vecs[6]  = '{OP_MUL,    32'h12345678, 32'd0,        5'd7,  32'd0,        ML};
    vecs[7]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, DL};
    vecs[8]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, DL};
    vecs[9]  = '{OP_DIVU,   32'd100,      32'd7,        5'd10, 32'd14,       DL};
    vecs[10] = '{OP_REMU,   32'd100,      32'd7,        5'd11, 32'd2,        DL};
    vecs[11] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, DL};
    vecs[12] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 5'd13, 32'd1,        DL};
    vecs[13] = '{OP_DIVU,   32'hFFFFFFFF, 32'd1,        5'd14, 32'hFFFFFFFF, DL};
    vecs[14] = '{OP_DIV,    32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 1};
    vecs[15] = '{OP_REMU,   32'd5,        32'd0,        5'd16, 32'd5,        1};
    vecs[16] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1};
    vecs[17] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        1};

    // Reset held low, then released
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.out_valid, bus.busy, bus.out_tag, bus.out_result}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_release_ready", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_valid(lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_result", i), 64'(bus.out_result), 64'(vecs[i].res));
      chk($sformatf("v%0d_tag", i), 64'(bus.out_tag), 64'(vecs[i].tag));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle_after", i), 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);
    end

    // Backpressure: result and tag held while out_ready is low
    bus.out_ready = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 5'd9);
    wait_valid(lat);
    chk("bp_latency", 64'(lat), 64'(DL));
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold_c%0d", c),
          64'({bus.out_valid, bus.in_ready, bus.busy, bus.out_tag, bus.out_result}),
          {25'd0, 1'b1, 1'b0, 1'b1, 5'd9, 32'd14});
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", 64'({bus.out_valid, bus.busy}), 64'd0);

    // Flush in BUSY cycle 12
    issue(OP_DIV, 32'd100, 32'd7, 5'd20);
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("flush_busy_before", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    #1;
    chk("flush_busy_after", 64'({bus.busy, bus.out_valid, bus.in_ready}), 64'b001);
    watch_no_valid("flush_busy_no_valid", 40);

    // Unit recovers cleanly after a flush
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd21);
    wait_valid(lat);
    chk("post_flush_latency", 64'(lat), 64'(DL));
    chk("post_flush_result", 64'({bus.out_tag, bus.out_result}), {27'd0, 5'd21, 32'hFFFFFFFD});
    @(posedge clk);
    #1;

    // Flush together with in_valid in IDLE: no accept
    @(negedge clk);
    bus.in_op = OP_DIV;
    bus.in_a = 32'd5;
    bus.in_b = 32'd0;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    #1;
    chk("flush_idle_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    chk("flush_idle_not_busy", 64'(bus.busy), 64'd0);
    watch_no_valid("flush_idle_no_valid", 5);

    // Async reset mid-BUSY
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd22);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {bus.out_valid, bus.busy, bus.out_tag, bus.out_result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_ready", 64'(bus.in_ready), 64'd1);
    watch_no_valid("rst_mid_no_stale", 40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
